elevator_scheduler: RTL and testbench

Collective-control request scheduler for a single elevator car. It latches cab and hall calls, tracks the car floor, chooses travel direction with up/down sweep (SCAN) ordering, and sequences the engine and door command outputs. It sits between the button panels and the car drive/door actuators. The car reports floor arrivals back to it.

---
 rtl/elevator_pkg.sv | 16 +
 rtl/elevator_req_mask.sv | 23 ++
 rtl/elevator_scheduler.sv | 225 ++++++++++++++++++++++
 tb/tb_elevator_scheduler.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// Shared codes for the elevator scheduler: engine/door output encodings and FSM states.
package elevator_pkg;

    localparam logic [1:0] ENG_STOP    = 2'b00;
    localparam logic [1:0] ENG_UP      = 2'b01;
    localparam logic [1:0] ENG_DOWN    = 2'b10;

    localparam logic [1:0] DOOR_CLOSED = 2'b00;
    localparam logic [1:0] DOOR_OPEN   = 2'b01;

    localparam logic [1:0] ST_IDLE     = 2'b00;
    localparam logic [1:0] ST_UP       = 2'b01;
    localparam logic [1:0] ST_DOWN     = 2'b10;
    localparam logic [1:0] ST_DOOR     = 2'b11;

endpackage

// File: rtl/elevator_req_mask.sv
// Reduces a request vector against the one-hot car floor into above / below / at-floor flags.
module elevator_req_mask #(
    parameter int FLOORS = 6
) (
    input  logic [FLOORS-1:0] req_i,
    input  logic [FLOORS-1:0] floor_i,
    output logic              above_o,
    output logic              below_o,
    output logic              at_o
);

    logic [FLOORS-1:0] below_mask;
    logic [FLOORS-1:0] above_mask;

    // floor_i is always one-hot, so subtracting one yields every lower floor.
    assign below_mask = floor_i - FLOORS'(1);
    assign above_mask = ~(below_mask | floor_i);

    assign above_o = |(req_i & above_mask);
    assign below_o = |(req_i & below_mask);
    assign at_o    = |(req_i & floor_i);

endmodule

// File: rtl/elevator_scheduler.sv
// Collective-control SCAN scheduler for one elevator car; optional parking via ELEVATOR_SCHED_PARK_EN.
module elevator_scheduler
    import elevator_pkg::*;
#(
    parameter int FLOORS     = 6,
    parameter int DOOR_TICKS = 8,
    parameter int PARK_TICKS = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [FLOORS-1:0] btn_num_in,
    input  logic [FLOORS-1:0] btn_up_out,
    input  logic [FLOORS-1:0] btn_down_out,
    input  logic              open_btn,
    input  logic              close_btn,
    input  logic              floor_arrive,
    output logic [1:0]        engine,
    output logic [1:0]        door,
    output logic [FLOORS-1:0] level_display,
    output logic [FLOORS-1:0] cab_lamp,
    output logic [FLOORS-1:0] up_lamp,
    output logic [FLOORS-1:0] down_lamp
);

    localparam int TW = $clog2(DOOR_TICKS + 1);
    localparam logic [TW-1:0] DOOR_LOAD = TW'(DOOR_TICKS);
    localparam logic [FLOORS-1:0] UP_VALID   = {1'b0, {(FLOORS-1){1'b1}}};
    localparam logic [FLOORS-1:0] DOWN_VALID = {{(FLOORS-1){1'b1}}, 1'b0};
    localparam logic [FLOORS-1:0] FLOOR0     = FLOORS'(1);

    logic [1:0]        state_q, state_d;
    logic [1:0]        engine_q, engine_d;
    logic [1:0]        door_q, door_d;
    logic [FLOORS-1:0] level_q, level_d;
    logic [FLOORS-1:0] cab_q, cab_d, up_q, up_d, down_q, down_d;
    logic [FLOORS-1:0] clr_cab, clr_up, clr_down;
    logic [TW-1:0]     timer_q, timer_d;
    logic              dir_up_q, dir_up_d;
    logic              arrived_q, arrived_d;
    logic              park_set;

    logic cab_above, cab_below, cab_at;
    logic up_above, up_below, up_at;
    logic down_above, down_below, down_at;
    logic any_above, any_below, any_at;
    logic door_reload;

    elevator_req_mask #(.FLOORS(FLOORS)) u_cab_mask (
        .req_i(cab_q), .floor_i(level_q),
        .above_o(cab_above), .below_o(cab_below), .at_o(cab_at)
    );
    elevator_req_mask #(.FLOORS(FLOORS)) u_up_mask (
        .req_i(up_q), .floor_i(level_q),
        .above_o(up_above), .below_o(up_below), .at_o(up_at)
    );
    elevator_req_mask #(.FLOORS(FLOORS)) u_down_mask (
        .req_i(down_q), .floor_i(level_q),
        .above_o(down_above), .below_o(down_below), .at_o(down_at)
    );

    assign any_above = cab_above | up_above | down_above;
    assign any_below = cab_below | down_below | up_below;
    assign any_at    = cab_at | up_at | down_at;

    // Calls at the open door's floor restart the dwell instead of being latched.
    assign door_reload = open_btn
                       | (|(btn_num_in & level_q))
                       | (dir_up_q ? |(btn_up_out & UP_VALID & level_q)
                                   : |(btn_down_out & DOWN_VALID & level_q));

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        state_d   = state_q;
        engine_d  = engine_q;
        door_d    = door_q;
        level_d   = level_q;
        dir_up_d  = dir_up_q;
        timer_d   = timer_q;
        arrived_d = 1'b0;
        clr_cab   = '0;
        clr_up    = '0;
        clr_down  = '0;

        case (state_q)
            ST_IDLE: begin
                if (any_at) begin
                    state_d  = ST_DOOR;
                    door_d   = DOOR_OPEN;
                    timer_d  = DOOR_LOAD;
                    clr_cab  = level_q;
                    clr_up   = level_q;
                    clr_down = level_q;
                end else if (any_above && (dir_up_q || !any_below)) begin
                    state_d  = ST_UP;
                    engine_d = ENG_UP;
                    dir_up_d = 1'b1;
                end else if (any_below) begin
                    state_d  = ST_DOWN;
                    engine_d = ENG_DOWN;
                    dir_up_d = 1'b0;
                end else if (open_btn) begin
                    state_d  = ST_DOOR;
                    door_d   = DOOR_OPEN;
                    timer_d  = DOOR_LOAD;
                end
            end

            ST_UP: begin
                if (arrived_q && (cab_at || up_at || !any_above)) begin
                    state_d  = ST_DOOR;
                    engine_d = ENG_STOP;
                    door_d   = DOOR_OPEN;
                    timer_d  = DOOR_LOAD;
                    clr_cab  = level_q;
                    clr_up   = level_q;
                    clr_down = any_above ? '0 : level_q;
                end else if (floor_arrive && !level_q[FLOORS-1]) begin
                    level_d   = level_q << 1;
                    arrived_d = 1'b1;
                end
            end

            ST_DOWN: begin
                if (arrived_q && (cab_at || down_at || !any_below)) begin
                    state_d  = ST_DOOR;
                    engine_d = ENG_STOP;
                    door_d   = DOOR_OPEN;
                    timer_d  = DOOR_LOAD;
                    clr_cab  = level_q;
                    clr_down = level_q;
                    clr_up   = any_below ? '0 : level_q;
                end else if (floor_arrive && !level_q[0]) begin
                    level_d   = level_q >> 1;
                    arrived_d = 1'b1;
                end
            end

            ST_DOOR: begin
                clr_cab  = level_q;
                clr_up   = dir_up_q ? level_q : '0;
                clr_down = dir_up_q ? '0 : level_q;
                if (door_reload) begin
                    timer_d = DOOR_LOAD;
                end else if (close_btn || timer_q <= TW'(1)) begin
                    state_d = ST_IDLE;
                    door_d  = DOOR_CLOSED;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end

            default: begin
                state_d  = ST_IDLE;
                engine_d = ENG_STOP;
                door_d   = DOOR_CLOSED;
            end
        endcase
    end

`ifdef ELEVATOR_SCHED_PARK_EN
    localparam int PW = $clog2(PARK_TICKS + 1);
    logic [PW-1:0] park_cnt_q, park_cnt_d;

    always_comb begin
        park_cnt_d = '0;
        park_set   = 1'b0;
        if (state_q == ST_IDLE && state_d == ST_IDLE
            && !(|{cab_q, up_q, down_q}) && !level_q[0]) begin
            if (park_cnt_q == PW'(PARK_TICKS - 1)) begin
                park_set = 1'b1;
            end else begin
                park_cnt_d = park_cnt_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) park_cnt_q <= '0;
        else        park_cnt_q <= park_cnt_d;
    end
`else
    assign park_set = 1'b0;
`endif

    // A clear in the same cycle as a press wins, so the served call cannot re-latch.
    assign cab_d  = (cab_q  | btn_num_in | (park_set ? FLOOR0 : '0)) & ~clr_cab;
    assign up_d   = (up_q   | (btn_up_out & UP_VALID))               & ~clr_up;
    assign down_d = (down_q | (btn_down_out & DOWN_VALID))           & ~clr_down;

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            engine_q  <= ENG_STOP;
            door_q    <= DOOR_CLOSED;
            level_q   <= FLOOR0;
            cab_q     <= '0;
            up_q      <= '0;
            down_q    <= '0;
            timer_q   <= '0;
            dir_up_q  <= 1'b1;
            arrived_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            engine_q  <= engine_d;
            door_q    <= door_d;
            level_q   <= level_d;
            cab_q     <= cab_d;
            up_q      <= up_d;
            down_q    <= down_d;
            timer_q   <= timer_d;
            dir_up_q  <= dir_up_d;
            arrived_q <= arrived_d;
        end
    end

    assign engine        = engine_q;
    assign door          = door_q;
    assign level_display = level_q;
    assign cab_lamp      = cab_q;
    assign up_lamp       = up_q;
    assign down_lamp     = down_q;

endmodule

// File: tb/tb_elevator_scheduler.sv
// Scoreboard bench for elevator_scheduler: expectations are queued with stimulus and drained after each edge.
module tb_elevator_scheduler;

    localparam int FLOORS = 6;

    logic              clk = 1'b0;
    logic              reset;
    logic [FLOORS-1:0] btn_num_in, btn_up_out, btn_down_out;
    logic              open_btn, close_btn, floor_arrive;
    logic [1:0]        engine, door;
    logic [FLOORS-1:0] level_display, cab_lamp, up_lamp, down_lamp;

    elevator_scheduler #(.FLOORS(FLOORS), .DOOR_TICKS(8), .PARK_TICKS(16)) dut (
        .clk(clk), .reset(reset),
        .btn_num_in(btn_num_in), .btn_up_out(btn_up_out), .btn_down_out(btn_down_out),
        .open_btn(open_btn), .close_btn(close_btn), .floor_arrive(floor_arrive),
        .engine(engine), .door(door), .level_display(level_display),
        .cab_lamp(cab_lamp), .up_lamp(up_lamp), .down_lamp(down_lamp)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int open_cnt = 0;

    typedef struct {
        string       field;
        string       tag;
        logic [31:0] exp;
    } exp_t;
    exp_t sb_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] observe(input string field);
        case (field)
            "eng":  return 32'(engine);
            "door": return 32'(door);
            "lvl":  return 32'(level_display);
            "cab":  return 32'(cab_lamp);
            "up":   return 32'(up_lamp);
            "down": return 32'(down_lamp);
            "open": return 32'(open_cnt);
            default: return 'x;
        endcase
    endfunction

    task automatic push(input string field, input string tag, input logic [31:0] v);
        exp_t e;
        e.field = field;
        e.tag   = tag;
        e.exp   = v;
        sb_q.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check(e.tag, observe(e.field), e.exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic arrive();
        floor_arrive = 1'b1;
        tick();
        floor_arrive = 1'b0;
        tick();
    endtask

    task automatic wait_door_closed();
        open_cnt = 0;
        while (door == 2'b01 && open_cnt < 40) begin
            tick();
            open_cnt++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b0;
        btn_num_in = '0; btn_up_out = '0; btn_down_out = '0;
        open_btn = 1'b0; close_btn = 1'b0; floor_arrive = 1'b0;

        // Reset, with buttons pressed to show nothing latches while held.
        btn_num_in = 6'b111111;
        tick(); tick();
        push("eng", "rst_engine", 2'b00);
        push("door", "rst_door", 2'b00);
        push("lvl", "rst_level", 6'b000001);
        push("cab", "rst_cab_hold", 6'b0);
        push("up", "rst_up", 6'b0);
        push("down", "rst_down", 6'b0);
        drain();
        btn_num_in = '0;
        reset = 1'b1;
        tick();

        // Single cab call to floor 3.
        btn_num_in = 6'b001000;
        tick();
        btn_num_in = '0;
        push("cab", "cab3_latched", 6'b001000);
        push("eng", "eng_before_move", 2'b00);
        drain();
        tick();
        push("eng", "eng_up_start", 2'b01);
        drain();
        arrive();
        push("lvl", "lvl_floor1", 6'b000010);
        push("eng", "eng_pass1", 2'b01);
        drain();
        arrive();
        arrive();
        push("lvl", "lvl_floor3", 6'b001000);
        push("eng", "eng_stop3", 2'b00);
        push("door", "door_open3", 2'b01);
        push("cab", "cab3_cleared", 6'b0);
        drain();
        wait_door_closed();
        push("open", "dwell_floor3", 8);
        drain();

        // Cab call back to floor 0.
        btn_num_in = 6'b000001;
        tick();
        btn_num_in = '0;
        tick();
        push("eng", "eng_down_start", 2'b10);
        drain();
        arrive(); arrive(); arrive();
        push("lvl", "lvl_floor0", 6'b000001);
        push("door", "door_open0", 2'b01);
        drain();
        wait_door_closed();

        // Door buttons while idle at floor 0.
        open_btn = 1'b1;
        tick();
        open_btn = 1'b0;
        push("door", "open_btn_opens", 2'b01);
        drain();
        for (int i = 0; i < 4; i++) tick();
        open_btn = 1'b1;
        tick();
        open_btn = 1'b0;
        wait_door_closed();
        push("open", "reopen_dwell", 8);
        drain();

        open_btn = 1'b1;
        tick();
        open_btn = 1'b0;
        tick(); tick();
        close_btn = 1'b1;
        tick();
        close_btn = 1'b0;
        push("door", "close_btn_closes", 2'b00);
        drain();

        open_btn = 1'b1;
        tick();
        open_btn = 1'b0;
        tick();
        open_btn = 1'b1; close_btn = 1'b1;
        tick();
        open_btn = 1'b0; close_btn = 1'b0;
        push("door", "open_beats_close", 2'b01);
        drain();
        wait_door_closed();
        push("open", "open_close_dwell", 8);
        drain();

        // Cab 5 + hall up 2 + hall down 3, all latched in one cycle.
        btn_num_in = 6'b100000; btn_up_out = 6'b000100; btn_down_out = 6'b001000;
        tick();
        btn_num_in = '0; btn_up_out = '0; btn_down_out = '0;
        push("cab", "scan_cab", 6'b100000);
        push("up", "scan_up", 6'b000100);
        push("down", "scan_down", 6'b001000);
        drain();
        tick();
        arrive();
        push("eng", "scan_pass1", 2'b01);
        drain();
        arrive();
        push("lvl", "scan_lvl2", 6'b000100);
        push("door", "scan_stop2", 2'b01);
        push("up", "scan_up2_clr", 6'b0);
        push("down", "scan_down3_kept", 6'b001000);
        drain();
        wait_door_closed();
        tick();
        push("eng", "scan_resume_up", 2'b01);
        drain();
        arrive();
        push("lvl", "scan_lvl3", 6'b001000);
        push("eng", "scan_pass3", 2'b01);
        push("door", "scan_pass3_door", 2'b00);
        drain();
        arrive(); arrive();
        push("lvl", "scan_lvl5", 6'b100000);
        push("door", "scan_stop5", 2'b01);
        push("cab", "scan_cab5_clr", 6'b0);
        drain();
        wait_door_closed();
        tick();
        push("eng", "scan_reverse", 2'b10);
        drain();
        arrive(); arrive();
        push("lvl", "scan_lvl3_down", 6'b001000);
        push("door", "scan_stop3", 2'b01);
        push("down", "scan_down3_clr", 6'b0);
        drain();

        // Cab call at the open door's floor restarts the dwell and is not latched.
        btn_num_in = 6'b001000;
        tick();
        btn_num_in = '0;
        push("cab", "door_cab_not_latched", 6'b0);
        drain();
        wait_door_closed();
        push("open", "door_cab_reload", 8);
        drain();
        tick();
        push("eng", "scan_idle_eng", 2'b00);
        push("door", "scan_idle_door", 2'b00);
        drain();

        // Ignored arrivals and ignored hall buttons.
        floor_arrive = 1'b1;
        tick();
        floor_arrive = 1'b0;
        push("lvl", "arrive_in_idle", 6'b001000);
        drain();
        open_btn = 1'b1;
        tick();
        open_btn = 1'b0;
        floor_arrive = 1'b1;
        tick();
        floor_arrive = 1'b0;
        push("lvl", "arrive_in_door", 6'b001000);
        drain();
        wait_door_closed();
        btn_up_out = 6'b100000; btn_down_out = 6'b000001;
        tick();
        btn_up_out = '0; btn_down_out = '0;
        push("up", "up_top_ignored", 6'b0);
        push("down", "down_bottom_ignored", 6'b0);
        drain();

        // Reset mid-move drops everything at once.
        btn_num_in = 6'b100000;
        tick();
        btn_num_in = '0;
        tick();
        arrive();
        reset = 1'b0;
        #1;
        push("eng", "midmove_rst_eng", 2'b00);
        push("lvl", "midmove_rst_lvl", 6'b000001);
        push("cab", "midmove_rst_cab", 6'b0);
        drain();
        tick();
        reset = 1'b1;
        tick();

`ifdef ELEVATOR_SCHED_PARK_EN
        btn_num_in = 6'b010000;
        tick();
        btn_num_in = '0;
        tick();
        arrive(); arrive(); arrive(); arrive();
        wait_door_closed();
        open_cnt = 0;
        while (cab_lamp[0] !== 1'b1 && open_cnt < 40) begin
            tick();
            open_cnt++;
        end
        push("open", "park_delay", 16);
        drain();
        tick();
        push("eng", "park_eng_down", 2'b10);
        drain();
        arrive(); arrive(); arrive(); arrive();
        push("lvl", "park_home", 6'b000001);
        push("door", "park_door", 2'b01);
        drain();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
